// File: rtl/capsense_pkg.sv
// Shared constants and helpers for the CapSense event queue.
// Event flag encoding and index-width sizing.
package capsense_pkg;

    localparam logic EVT_PRESS   = 1'b1;
    localparam logic EVT_RELEASE = 1'b0;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/capsense_evt_fifo.sv
// Event FIFO with registered occupancy.
// The head word reads as zero whenever the FIFO is empty.
module capsense_evt_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 8,
    localparam int AW   = (DEPTH <= 1) ? 1 : $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic [CW-1:0] o_count,
    output logic          o_full
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;

    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    // A pop on the same edge frees the slot a full FIFO needs.
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/capsense_event_queue.sv
// CapSense button edge detector feeding a press/release event FIFO.
// One pending slot per button; lowest index wins the single push per cycle.
module capsense_event_queue
    import capsense_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 8,
    parameter int IW    = idx_width(N),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  buttons_i,
    output logic          evt_valid_o,
    input  logic          evt_ready_i,
    output logic [IW:0]   evt_code_o,
    output logic [CW-1:0] evt_count_o,
    output logic          overflow_o,
    input  logic          clr_ovf_i
);

    logic [N-1:0] r_prev;
    logic [N-1:0] r_pend;
    logic [N-1:0] r_lvl;
    logic         r_ovf;

    logic [N-1:0]  w_change;
    logic [N-1:0]  w_push_oh;
    logic [IW-1:0] w_idx;
    logic          w_any;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_flag;
    logic          w_ovf_set;
    logic [CW-1:0] w_count;

    assign w_change = buttons_i ^ r_prev;

    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_any = 1'b1;
                w_idx = IW'(i);
            end
        end
    end

    assign w_pop     = evt_valid_o & evt_ready_i;
    assign w_push    = w_any & (~w_full | w_pop);
    assign w_push_oh = w_push ? (N'(1) << w_idx) : '0;
    assign w_flag    = r_lvl[w_idx] ? EVT_PRESS : EVT_RELEASE;
    // A change on a slot being pushed this edge loses nothing.
    assign w_ovf_set = |(w_change & r_pend & ~w_push_oh);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_prev <= '0;
            r_pend <= '0;
            r_lvl  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_prev <= buttons_i;
            r_pend <= (r_pend & ~w_push_oh) | w_change;
            r_lvl  <= (r_lvl & ~w_change) | (buttons_i & w_change);
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (clr_ovf_i)
                r_ovf <= 1'b0;
        end
    end

    capsense_evt_fifo #(
        .W     (IW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_i),
        .i_push  (w_push),
        .i_data  ({w_flag, w_idx}),
        .i_pop   (w_pop),
        .o_data  (evt_code_o),
        .o_count (w_count),
        .o_full  (w_full)
    );

    assign evt_count_o = w_count;
    assign evt_valid_o = (w_count != '0);
    assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_capsense_event_queue.sv
// Directed bench for capsense_event_queue (N=4, DEPTH=8).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_capsense_event_queue;

    logic       clk_i;
    logic       rst_i;
    logic [3:0] buttons_i;
    logic       evt_valid_o;
    logic       evt_ready_i;
    logic [2:0] evt_code_o;
    logic [3:0] evt_count_o;
    logic       overflow_o;
    logic       clr_ovf_i;

    int n_tests;
    int n_fail;
    logic [2:0] exp_q [$];

    capsense_event_queue #(
        .N     (4),
        .DEPTH (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .buttons_i   (buttons_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_code_o  (evt_code_o),
        .evt_count_o (evt_count_o),
        .overflow_o  (overflow_o),
        .clr_ovf_i   (clr_ovf_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drain(input string tag);
        evt_ready_i = 1'b1;
        foreach (exp_q[j]) begin
            chk({tag, "_valid"}, 32'(evt_valid_o), 32'd1);
            chk({tag, "_code"}, 32'(evt_code_o), 32'(exp_q[j]));
            tick();
        end
        evt_ready_i = 1'b0;
        chk({tag, "_empty"}, 32'(evt_count_o), 32'd0);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_i       = 1'b0;
        buttons_i   = 4'b0000;
        evt_ready_i = 1'b0;
        clr_ovf_i   = 1'b0;
        #1;
        tick();
        tick();
        tick();
        chk("rst_valid", 32'(evt_valid_o), 32'd0);
        chk("rst_count", 32'(evt_count_o), 32'd0);
        chk("rst_code", 32'(evt_code_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        rst_i = 1'b1;
        tick();
        tick();

        // Single press, then release
        buttons_i = 4'b0100;
        tick();
        chk("lat_not_yet", 32'(evt_valid_o), 32'd0);
        tick();
        chk("press2_valid", 32'(evt_valid_o), 32'd1);
        chk("press2_code", 32'(evt_code_o), 32'b110);
        chk("press2_count", 32'(evt_count_o), 32'd1);
        evt_ready_i = 1'b1;
        tick();
        evt_ready_i = 1'b0;
        chk("pop_empty", 32'(evt_valid_o), 32'd0);
        buttons_i = 4'b0000;
        tick();
        tick();
        chk("rel2_code", 32'(evt_code_o), 32'b010);
        evt_ready_i = 1'b1;
        tick();
        evt_ready_i = 1'b0;
        chk("rel2_popped", 32'(evt_count_o), 32'd0);

        // Three simultaneous presses, priority order
        buttons_i = 4'b1011;
        tick();
        tick();
        chk("multi_ev0", 32'(evt_code_o), 32'b100);
        evt_ready_i = 1'b1;
        tick();
        chk("multi_ev1", 32'(evt_code_o), 32'b101);
        chk("multi_cnt1", 32'(evt_count_o), 32'd1);
        tick();
        chk("multi_ev3", 32'(evt_code_o), 32'b111);
        tick();
        evt_ready_i = 1'b0;
        chk("multi_done", 32'(evt_count_o), 32'd0);

        // Ten changes with consumer stalled
        buttons_i = 4'b1010; tick();
        buttons_i = 4'b1000; tick();
        buttons_i = 4'b1100; tick();
        buttons_i = 4'b0100; tick();
        buttons_i = 4'b0101; tick();
        buttons_i = 4'b0111; tick();
        buttons_i = 4'b0011; tick();
        buttons_i = 4'b1011; tick();
        buttons_i = 4'b1010; tick();
        buttons_i = 4'b1000; tick();
        tick();
        chk("sat_count", 32'(evt_count_o), 32'd8);
        chk("sat_ovf", 32'(overflow_o), 32'd0);
        exp_q = '{3'b000, 3'b001, 3'b110, 3'b011, 3'b100,
                  3'b101, 3'b010, 3'b111, 3'b000, 3'b001};
        drain("sat_drain");

        // Full FIFO: push and pop on the same edge
        buttons_i = 4'b1001; tick();
        buttons_i = 4'b1011; tick();
        buttons_i = 4'b1111; tick();
        buttons_i = 4'b0111; tick();
        buttons_i = 4'b0110; tick();
        buttons_i = 4'b0100; tick();
        buttons_i = 4'b0000; tick();
        buttons_i = 4'b1000; tick();
        tick();
        buttons_i = 4'b1001;
        tick();
        chk("full_blocked", 32'(evt_count_o), 32'd8);
        evt_ready_i = 1'b1;
        tick();
        chk("full_pushpop", 32'(evt_count_o), 32'd8);
        exp_q = '{3'b101, 3'b110, 3'b011, 3'b000,
                  3'b001, 3'b010, 3'b111, 3'b100};
        drain("full_drain");

        // Button 2 toggles twice while stuck pending
        buttons_i = 4'b1000; tick();
        buttons_i = 4'b1010; tick();
        buttons_i = 4'b0010; tick();
        buttons_i = 4'b0011; tick();
        buttons_i = 4'b0001; tick();
        buttons_i = 4'b1001; tick();
        buttons_i = 4'b1000; tick();
        buttons_i = 4'b1010; tick();
        tick();
        chk("ovf_before", 32'(overflow_o), 32'd0);
        buttons_i = 4'b1110;
        tick();
        buttons_i = 4'b1010;
        tick();
        chk("ovf_set", 32'(overflow_o), 32'd1);
        chk("ovf_count", 32'(evt_count_o), 32'd8);
        exp_q = '{3'b000, 3'b101, 3'b011, 3'b100, 3'b001,
                  3'b111, 3'b000, 3'b101, 3'b010};
        drain("ovf_drain");
        chk("ovf_sticky", 32'(overflow_o), 32'd1);
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
        chk("ovf_clr", 32'(overflow_o), 32'd0);

        // Asynchronous reset with queued events
        buttons_i = 4'b1011; tick();
        buttons_i = 4'b1001; tick();
        buttons_i = 4'b1101; tick();
        buttons_i = 4'b0101; tick();
        buttons_i = 4'b0100; tick();
        tick();
        chk("q5_count", 32'(evt_count_o), 32'd5);
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_valid", 32'(evt_valid_o), 32'd0);
        chk("arst_count", 32'(evt_count_o), 32'd0);
        chk("arst_code", 32'(evt_code_o), 32'd0);
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        tick();
        chk("held_valid", 32'(evt_valid_o), 32'd1);
        chk("held_code", 32'(evt_code_o), 32'b110);
        chk("held_count", 32'(evt_count_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
